// File: rtl/wb_rob_multiport.sv
// In-order writeback/commit unit: ROB allocation, out-of-order completion on
// several ports, single-commit retirement, precise exceptions and id-based bypass.
module wb_rob_multiport #(
  parameter int NUM_ENTRIES   = 8,
  parameter int ID_W          = $clog2(NUM_ENTRIES),
  parameter int NUM_WB_PORTS  = 3,
  parameter int NUM_BYP_PORTS = 4,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int PC_W          = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              alloc_valid,
  input  logic [ADDR_W-1:0]                 alloc_dest,
  input  logic                              alloc_wr_rf,
  input  logic [PC_W-1:0]                   alloc_pc,
  output logic                              alloc_ready,
  output logic [ID_W-1:0]                   alloc_id,
  output logic                              rob_full,
  output logic                              rob_empty,
  output logic [ID_W-1:0]                   rob_oldest,
  input  logic [NUM_WB_PORTS-1:0]           wb_valid,
  input  logic [NUM_WB_PORTS*ID_W-1:0]      wb_id,
  input  logic [NUM_WB_PORTS*DATA_W-1:0]    wb_data,
  input  logic [NUM_WB_PORTS-1:0]           wb_xcpt,
  input  logic [NUM_WB_PORTS*DATA_W-1:0]    wb_xcpt_addr,
  output logic                              rf_we,
  output logic [ADDR_W-1:0]                 rf_dest,
  output logic [DATA_W-1:0]                 rf_data,
  output logic [ID_W-1:0]                   rf_id,
  output logic                              xcpt_valid,
  output logic [PC_W-1:0]                   xcpt_pc,
  output logic [DATA_W-1:0]                 xcpt_addr,
  output logic                              flush,
  input  logic [NUM_BYP_PORTS*ID_W-1:0]     byp_id,
  output logic [NUM_BYP_PORTS-1:0]          byp_hit,
  output logic [NUM_BYP_PORTS*DATA_W-1:0]   byp_data
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] done_q, done_d;
  logic [NUM_ENTRIES-1:0] xcpt_q, xcpt_d;
  logic [NUM_ENTRIES-1:0] wr_rf_q, wr_rf_d;
  logic [ADDR_W-1:0]      dest_q  [NUM_ENTRIES];
  logic [ADDR_W-1:0]      dest_d  [NUM_ENTRIES];
  logic [PC_W-1:0]        pc_q    [NUM_ENTRIES];
  logic [PC_W-1:0]        pc_d    [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_q  [NUM_ENTRIES];
  logic [DATA_W-1:0]      data_d  [NUM_ENTRIES];
  logic [DATA_W-1:0]      xaddr_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      xaddr_d [NUM_ENTRIES];
  logic [ID_W-1:0]        head_q, head_d;
  logic [ID_W-1:0]        tail_q, tail_d;
  logic [ID_W:0]          count_q, count_d;
  logic                   flush_pending_q, flush_pending_d;

  logic head_ok;
  logic normal_commit;
  logic xcpt_commit;
  logic alloc_fire;

  assign rob_full      = (count_q == (ID_W+1)'(NUM_ENTRIES));
  assign rob_empty     = (count_q == '0);
  assign alloc_ready   = ~rob_full & ~flush_pending_q;
  assign alloc_fire    = alloc_valid & alloc_ready;
  assign alloc_id      = tail_q;
  assign rob_oldest    = head_q;
  assign flush         = flush_pending_q;

  // The exception entry stays valid until the flush, so block its re-commit.
  assign head_ok       = valid_q[head_q] & done_q[head_q] & ~flush_pending_q;
  assign normal_commit = head_ok & ~xcpt_q[head_q];
  assign xcpt_commit   = head_ok & xcpt_q[head_q];

  assign rf_we      = normal_commit & wr_rf_q[head_q];
  assign rf_dest    = normal_commit ? dest_q[head_q] : '0;
  assign rf_data    = normal_commit ? data_q[head_q] : '0;
  assign rf_id      = normal_commit ? head_q : '0;
  assign xcpt_valid = xcpt_commit;
  assign xcpt_pc    = xcpt_commit ? pc_q[head_q] : '0;
  assign xcpt_addr  = xcpt_commit ? xaddr_q[head_q] : '0;

  always_comb begin
    valid_d         = valid_q;
    done_d          = done_q;
    xcpt_d          = xcpt_q;
    wr_rf_d         = wr_rf_q;
    dest_d          = dest_q;
    pc_d            = pc_q;
    data_d          = data_q;
    xaddr_d         = xaddr_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    flush_pending_d = 1'b0;

    if (flush_pending_q) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Walk ports high to low so the lowest matching port is written last.
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        for (int p = NUM_WB_PORTS-1; p >= 0; p--) begin
          if (wb_valid[p] && (wb_id[p*ID_W +: ID_W] == ID_W'(e)) &&
              valid_q[e] && !done_q[e]) begin
            done_d[e]  = 1'b1;
            data_d[e]  = wb_data[p*DATA_W +: DATA_W];
            xcpt_d[e]  = wb_xcpt[p];
            xaddr_d[e] = wb_xcpt_addr[p*DATA_W +: DATA_W];
          end
        end
      end

      if (normal_commit) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + ID_W'(1);
      end
      flush_pending_d = xcpt_commit;

      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        xcpt_d[tail_q]  = 1'b0;
        wr_rf_d[tail_q] = alloc_wr_rf;
        dest_d[tail_q]  = alloc_dest;
        pc_d[tail_q]    = alloc_pc;
        tail_d          = tail_q + ID_W'(1);
      end

      count_d = count_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(normal_commit);
    end
  end

  always_comb begin
    byp_hit  = '0;
    byp_data = '0;
    for (int b = 0; b < NUM_BYP_PORTS; b++) begin
      if (valid_q[byp_id[b*ID_W +: ID_W]] && done_q[byp_id[b*ID_W +: ID_W]] &&
          !xcpt_q[byp_id[b*ID_W +: ID_W]]) begin
        byp_hit[b]                   = 1'b1;
        byp_data[b*DATA_W +: DATA_W] = data_q[byp_id[b*ID_W +: ID_W]];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q         <= '0;
      done_q          <= '0;
      xcpt_q          <= '0;
      wr_rf_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        dest_q[e]  <= '0;
        pc_q[e]    <= '0;
        data_q[e]  <= '0;
        xaddr_q[e] <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      done_q          <= done_d;
      xcpt_q          <= xcpt_d;
      wr_rf_q         <= wr_rf_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
      dest_q          <= dest_d;
      pc_q            <= pc_d;
      data_q          <= data_d;
      xaddr_q         <= xaddr_d;
    end
  end

endmodule

// File: tb/tb_wb_rob_multiport.sv
// Scoreboard bench for wb_rob_multiport: allocation order is queued and every
// commit is popped and compared against the model of dest/data per id.
module tb_wb_rob_multiport;
  localparam int NE   = 8;
  localparam int IW   = 3;
  localparam int NWB  = 3;
  localparam int NBYP = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int PW   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_dest;
  logic              alloc_wr_rf;
  logic [PW-1:0]     alloc_pc;
  logic              alloc_ready;
  logic [IW-1:0]     alloc_id;
  logic              rob_full, rob_empty;
  logic [IW-1:0]     rob_oldest;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*IW-1:0] wb_id;
  logic [NWB*DW-1:0] wb_data;
  logic [NWB-1:0]    wb_xcpt;
  logic [NWB*DW-1:0] wb_xcpt_addr;
  logic              rf_we;
  logic [AW-1:0]     rf_dest;
  logic [DW-1:0]     rf_data;
  logic [IW-1:0]     rf_id;
  logic              xcpt_valid;
  logic [PW-1:0]     xcpt_pc;
  logic [DW-1:0]     xcpt_addr;
  logic              flush;
  logic [NBYP*IW-1:0] byp_id;
  logic [NBYP-1:0]    byp_hit;
  logic [NBYP*DW-1:0] byp_data;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  logic [AW-1:0] exp_dest [NE];
  logic [DW-1:0] exp_data [NE];

  wb_rob_multiport #(
    .NUM_ENTRIES(NE), .ID_W(IW), .NUM_WB_PORTS(NWB), .NUM_BYP_PORTS(NBYP),
    .DATA_W(DW), .ADDR_W(AW), .PC_W(PW)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_wr_rf(alloc_wr_rf),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_oldest(rob_oldest),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_xcpt(wb_xcpt),
    .wb_xcpt_addr(wb_xcpt_addr),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .rf_id(rf_id),
    .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_addr(xcpt_addr),
    .flush(flush), .byp_id(byp_id), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clock = ~clock;

  task automatic clear_wb();
    wb_valid = '0; wb_id = '0; wb_data = '0; wb_xcpt = '0; wb_xcpt_addr = '0;
  endtask

  task automatic set_wb(input int p, input int id, input logic [DW-1:0] d,
                        input logic x, input logic [DW-1:0] a);
    wb_valid[p]            = 1'b1;
    wb_id[p*IW +: IW]      = IW'(id);
    wb_data[p*DW +: DW]    = d;
    wb_xcpt[p]             = x;
    wb_xcpt_addr[p*DW +: DW] = a;
  endtask

  // Settle combinational outputs and score any commit seen this cycle.
  task automatic settle();
    int eid;
    #1;
    if (rf_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: got id %0d data %h, required no commit", rf_id, rf_data);
      end else begin
        eid = exp_q.pop_front();
        if (rf_id !== IW'(eid) || rf_dest !== exp_dest[eid] || rf_data !== exp_data[eid]) begin
          fails++;
          $display("FAIL commit: got id %0d dest %0d data %h, required id %0d dest %0d data %h",
                   rf_id, rf_dest, rf_data, eid, exp_dest[eid], exp_data[eid]);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_alloc(input int dest, input logic [PW-1:0] pc, input int exp_id);
    alloc_valid = 1'b1;
    alloc_dest  = AW'(dest);
    alloc_wr_rf = 1'b1;
    alloc_pc    = pc;
    settle();
    tests++;
    if (alloc_ready !== 1'b1 || alloc_id !== IW'(exp_id)) begin
      fails++;
      $display("FAIL alloc: got ready %b id %0d, required ready 1 id %0d", alloc_ready, alloc_id, exp_id);
    end
    exp_q.push_back(exp_id);
    exp_dest[exp_id] = AW'(dest);
    advance();
    alloc_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      settle();
      advance();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    advance();
    settle();
    tests++;
    if (rf_we !== 1'b0 || xcpt_valid !== 1'b0 || flush !== 1'b0 || rob_empty !== 1'b1 ||
        rob_full !== 1'b0 || alloc_id !== '0 || alloc_ready !== 1'b1 || rf_data !== '0 ||
        xcpt_pc !== '0 || byp_hit !== '0 || byp_data !== '0) begin
      fails++;
      $display("FAIL reset_state: got we %b xv %b fl %b empty %b full %b id %0d rdy %b, required 0 0 0 1 0 0 1",
               rf_we, xcpt_valid, flush, rob_empty, rob_full, alloc_id, alloc_ready);
    end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_inorder();
    for (int i = 0; i < 3; i++) do_alloc(i + 1, 32'h100 + 32'(4*i), i);
    set_wb(2, 2, 32'hC, 1'b0, '0); exp_data[2] = 32'hC;
    settle(); advance(); clear_wb();
    set_wb(0, 0, 32'hA, 1'b0, '0); exp_data[0] = 32'hA;
    settle(); advance(); clear_wb();
    set_wb(1, 1, 32'hB, 1'b0, '0); exp_data[1] = 32'hB;
    for (int c = 0; c < 3; c++) begin
      settle();
      tests++;
      if (rf_we !== 1'b1) begin
        fails++;
        $display("FAIL inorder_consecutive: cycle %0d got rf_we %b, required 1", c, rf_we);
      end
      advance();
      clear_wb();
    end
    settle();
    tests++;
    if (rob_empty !== 1'b1 || rf_we !== 1'b0) begin
      fails++;
      $display("FAIL inorder_empty: got empty %b we %b, required 1 0", rob_empty, rf_we);
    end
    advance();
  endtask

  task automatic test_full_wrap();
    pulse_reset();
    for (int i = 0; i < NE; i++) do_alloc(10 + i, 32'h300 + 32'(4*i), i);
    settle();
    tests++;
    if (rob_full !== 1'b1 || alloc_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_flags: got full %b ready %b, required 1 0", rob_full, alloc_ready);
    end
    advance();
    set_wb(0, 0, 32'h10, 1'b0, '0); exp_data[0] = 32'h10;
    settle(); advance(); clear_wb();
    alloc_valid = 1'b1; alloc_dest = 5'd31; alloc_pc = 32'hDEAD;
    settle();
    tests++;
    if (alloc_ready !== 1'b0 || rf_we !== 1'b1) begin
      fails++;
      $display("FAIL full_alloc_reject: got ready %b we %b, required 0 1", alloc_ready, rf_we);
    end
    advance();
    alloc_valid = 1'b0;
    settle();
    tests++;
    if (alloc_id !== 3'd0 || rob_full !== 1'b0) begin
      fails++;
      $display("FAIL full_after_reject: got id %0d full %b, required 0 0", alloc_id, rob_full);
    end
    advance();
    set_wb(0, 1, 32'h11, 1'b0, '0); exp_data[1] = 32'h11;
    set_wb(1, 2, 32'h12, 1'b0, '0); exp_data[2] = 32'h12;
    settle(); advance(); clear_wb();
    settle(); advance();
    settle(); advance();
    tests++;
    if (exp_q.size() != 5) begin
      fails++;
      $display("FAIL full_commits: got %0d pending, required 5", exp_q.size());
    end
    for (int i = 0; i < 3; i++) do_alloc(20 + i, 32'h400 + 32'(4*i), i);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        d = $urandom;
        set_wb(i % NWB, (i - 1) % NE, d, 1'b0, '0);
        exp_data[(i - 1) % NE] = d;
      end
      do_alloc(i, 32'h500 + 32'(4*i), i % NE);
      clear_wb();
    end
    d = $urandom;
    set_wb(0, 9 % NE, d, 1'b0, '0); exp_data[9 % NE] = d;
    settle(); advance(); clear_wb();
    drain(6);
    settle();
    tests++;
    if (rob_empty !== 1'b1 || alloc_id !== 3'd2) begin
      fails++;
      $display("FAIL b2b_end: got empty %b id %0d, required 1 2", rob_empty, alloc_id);
    end
    advance();
  endtask

  task automatic test_exception();
    pulse_reset();
    for (int i = 0; i < 4; i++) do_alloc(i + 1, (i == 1) ? 32'h200 : 32'h600 + 32'(4*i), i);
    set_wb(1, 1, 32'h0, 1'b1, 32'h1000);
    settle(); advance(); clear_wb();
    set_wb(0, 0, 32'h20, 1'b0, '0); exp_data[0] = 32'h20;
    set_wb(1, 2, 32'h21, 1'b0, '0);
    set_wb(2, 3, 32'h22, 1'b0, '0);
    settle();
    advance(); clear_wb();
    settle();
    tests++;
    if (rf_we !== 1'b1 || rf_id !== 3'd0 || xcpt_valid !== 1'b0) begin
      fails++;
      $display("FAIL xcpt_first_commit: got we %b id %0d xv %b, required 1 0 0", rf_we, rf_id, xcpt_valid);
    end
    advance();
    exp_q.delete();
    settle();
    tests++;
    if (xcpt_valid !== 1'b1 || xcpt_pc !== 32'h200 || xcpt_addr !== 32'h1000 || rf_we !== 1'b0) begin
      fails++;
      $display("FAIL xcpt_commit: got xv %b pc %h addr %h we %b, required 1 200 1000 0",
               xcpt_valid, xcpt_pc, xcpt_addr, rf_we);
    end
    advance();
    alloc_valid = 1'b1;
    set_wb(0, 0, 32'h99, 1'b0, '0);
    settle();
    tests++;
    if (flush !== 1'b1 || alloc_ready !== 1'b0 || rf_we !== 1'b0 || xcpt_valid !== 1'b0) begin
      fails++;
      $display("FAIL xcpt_flush: got flush %b ready %b we %b xv %b, required 1 0 0 0",
               flush, alloc_ready, rf_we, xcpt_valid);
    end
    advance();
    alloc_valid = 1'b0;
    clear_wb();
    settle();
    tests++;
    if (rob_empty !== 1'b1 || alloc_id !== 3'd0 || flush !== 1'b0 || rob_oldest !== 3'd0) begin
      fails++;
      $display("FAIL xcpt_after_flush: got empty %b id %0d flush %b head %0d, required 1 0 0 0",
               rob_empty, alloc_id, flush, rob_oldest);
    end
    advance();
  endtask

  task automatic test_port_conflict();
    pulse_reset();
    for (int i = 0; i < 5; i++) do_alloc(i + 1, 32'h700 + 32'(4*i), i);
    set_wb(0, 4, 32'h11, 1'b0, '0);
    set_wb(2, 4, 32'h22, 1'b0, '0);
    byp_id = '0;
    byp_id[0 +: IW] = 3'd4;
    settle();
    tests++;
    if (byp_hit[0] !== 1'b0) begin
      fails++;
      $display("FAIL conflict_no_forward: got hit %b, required 0", byp_hit[0]);
    end
    advance(); clear_wb();
    settle();
    tests++;
    if (byp_hit[0] !== 1'b1 || byp_data[0 +: DW] !== 32'h11) begin
      fails++;
      $display("FAIL conflict_low_port: got hit %b data %h, required 1 11", byp_hit[0], byp_data[0 +: DW]);
    end
    advance();
    set_wb(1, 4, 32'h33, 1'b0, '0);
    settle(); advance(); clear_wb();
    settle();
    tests++;
    if (byp_hit[0] !== 1'b1 || byp_data[0 +: DW] !== 32'h11) begin
      fails++;
      $display("FAIL conflict_done_ignored: got hit %b data %h, required 1 11", byp_hit[0], byp_data[0 +: DW]);
    end
    advance();
  endtask

  task automatic test_bypass();
    pulse_reset();
    for (int i = 0; i < 6; i++) do_alloc(i + 1, 32'h800 + 32'(4*i), i);
    set_wb(0, 3, 32'h55, 1'b0, '0);
    set_wb(1, 2, 32'h77, 1'b1, 32'h40);
    settle(); advance(); clear_wb();
    byp_id = {3'd3, 3'd5, 3'd7, 3'd3};
    settle();
    tests++;
    if (byp_hit !== 4'b1001 || byp_data !== {32'h55, 32'h0, 32'h0, 32'h55}) begin
      fails++;
      $display("FAIL bypass_lookup: got hit %b data %h, required 1001 55/0/0/55", byp_hit, byp_data);
    end
    advance();
    byp_id = {3'd3, 3'd5, 3'd2, 3'd3};
    settle();
    tests++;
    if (byp_hit !== 4'b1001 || byp_data !== {32'h55, 32'h0, 32'h0, 32'h55}) begin
      fails++;
      $display("FAIL bypass_xcpt_miss: got hit %b data %h, required 1001 55/0/0/55", byp_hit, byp_data);
    end
    advance();
    byp_id = '0;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int i = 0; i < 5; i++) do_alloc(i + 1, 32'h900 + 32'(4*i), i);
    set_wb(0, 0, 32'hA0, 1'b0, '0); exp_data[0] = 32'hA0;
    set_wb(1, 1, 32'hA1, 1'b0, '0); exp_data[1] = 32'hA1;
    set_wb(2, 2, 32'hA2, 1'b0, '0); exp_data[2] = 32'hA2;
    settle(); advance(); clear_wb();
    settle();
    #1 reset = 1'b1;
    #1;
    tests++;
    if (rf_we !== 1'b0 || rob_empty !== 1'b1 || alloc_id !== 3'd0 || rf_data !== '0 ||
        rf_dest !== '0 || rob_oldest !== 3'd0 || byp_hit !== '0) begin
      fails++;
      $display("FAIL reset_mid_immediate: got we %b empty %b id %0d data %h, required 0 1 0 0",
               rf_we, rob_empty, alloc_id, rf_data);
    end
    exp_q.delete();
    advance();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      tests++;
      if (rf_we !== 1'b0 || rob_empty !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_after: cycle %0d got we %b empty %b, required 0 1", c, rf_we, rob_empty);
      end
      advance();
    end
  endtask

  initial begin
    reset       = 1'b1;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    alloc_wr_rf = 1'b0;
    alloc_pc    = '0;
    byp_id      = '0;
    clear_wb();
    test_reset();
    test_inorder();
    test_full_wrap();
    test_back_to_back();
    test_exception();
    test_port_conflict();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_rob_multiport.md
Name: wb_rob_multiport

Overview:
- Parametrised in-order writeback/commit unit; successor to the single-instance writeback top.
- Allocates a reorder buffer (ROB) entry per issued instruction.
- Accepts out-of-order completions on NUM_WB_PORTS execution ports and retires up to one instruction per cycle to the register file.
- Reports precise exceptions, flushes itself one cycle after an exception commit, and serves NUM_BYP_PORTS bypass lookups by ROB id.

Parameters:
- NUM_ENTRIES, 8, ROB depth; power of 2, minimum 2.
- ID_W, $clog2(NUM_ENTRIES), ROB id width.
- NUM_WB_PORTS, 3, completion ports (ALU, MUL, cache by default).
- NUM_BYP_PORTS, 4, bypass lookup ports.
- DATA_W, 32, result width.
- ADDR_W, 5, RF destination address width.
- PC_W, 32, PC width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alloc_valid  in  1  request one entry
- alloc_dest  in  ADDR_W  RF destination
- alloc_wr_rf  in  1  instruction writes RF
- alloc_pc  in  PC_W  instruction PC
- alloc_ready  out  1  ~full & ~flush_pending
- alloc_id  out  ID_W  id granted (current tail)
- rob_full  out  1  count==NUM_ENTRIES
- rob_empty  out  1  count==0
- rob_oldest  out  ID_W  head id
- wb_valid  in  NUM_WB_PORTS  completion strobes
- wb_id  in  NUM_WB_PORTS*ID_W  completing ids
- wb_data  in  NUM_WB_PORTS*DATA_W  results
- wb_xcpt  in  NUM_WB_PORTS  completion raised exception
- wb_xcpt_addr  in  NUM_WB_PORTS*DATA_W  faulting address
- rf_we  out  1  commit write enable
- rf_dest  out  ADDR_W  commit destination
- rf_data  out  DATA_W  commit data
- rf_id  out  ID_W  committed id
- xcpt_valid  out  1  exception commit pulse
- xcpt_pc  out  PC_W  faulting PC
- xcpt_addr  out  DATA_W  faulting address
- flush  out  1  ROB invalidated this cycle
- byp_id  in  NUM_BYP_PORTS*ID_W  lookup ids
- byp_hit  out  NUM_BYP_PORTS  entry valid & done & ~xcpt
- byp_data  out  NUM_BYP_PORTS*DATA_W  entry data, 0 on miss

Behaviour:
- Reset (async): head, tail, count = 0; all entries invalid; flush_pending = 0.
- Outputs during and after reset until the first event: rf_we, xcpt_valid, flush = 0; rob_empty = 1; rob_full = 0; alloc_id = 0; all data outputs 0.
- Allocation: alloc_valid & alloc_ready writes the tail entry {valid=1, done=0, xcpt=0, dest, wr_rf, pc}, then tail++ (mod NUM_ENTRIES). Accepted allocations do not depend on commit.
- Allocation when full: rejected even if a commit happens in the same cycle; full is evaluated on the registered count.
- Completion: wb_valid[p] to a valid, not-done entry sets done=1 and stores data, xcpt and xcpt_addr at the clock edge.
- Ignored completions: completion to an invalid or already-done id is dropped.
- Same-id completions in one cycle: the lowest port index wins.
- Completion to the entry being allocated in the same cycle: the allocation wins; this is a stimulus error.
- Commit is combinational from the head entry registers, one per cycle. When head is valid & done:
  - xcpt=0: rf_we = wr_rf; rf_dest, rf_data, rf_id = head fields; entry invalidated; head++.
  - xcpt=1: xcpt_valid = 1 with pc and addr; rf_we = 0; flush_pending is set.
- Flush: in the cycle after an exception commit, flush = 1. All entries are invalidated and head = tail = count = 0. Allocations and completions in that cycle are ignored, alloc_ready = 0, and no commit occurs. flush_pending clears.
- Count update each cycle: count += alloc_accepted - normal_commit. Simultaneous alloc and commit leaves count unchanged. Pointers wrap with ID_W-bit arithmetic.
- Bypass: combinational lookup of the registered entry state; same-cycle completions are not forwarded.
- Reset mid-operation: all state is cleared immediately; no partial commit is output.

Test Plan:
- In-order basic: alloc ids 0,1,2; complete 2,0,1 with 0xA,0xB,0xC on ports 0,1,2 → commits id0/0xA, id1/0xB, id2/0xC on consecutive cycles; rob_empty = 1 after.
- Full/wrap: NUM_ENTRIES=8; alloc 8 → rob_full = 1 and alloc_ready = 0. 9th alloc with a commit in the same cycle is rejected. After 3 commits, 3 new allocs receive ids 0,1,2.
- Exception: alloc 0..3; complete id1 with xcpt, addr 0x1000, pc 0x200; complete 0, 2, 3 → id0 commits; next cycle xcpt_valid with pc 0x200, addr 0x1000, rf_we = 0; next cycle flush = 1; afterwards rob_empty = 1 and alloc_id = 0.
- Port conflict: ports 0 and 2 both complete id4 with 0x11/0x22 → entry data = 0x11; later completion to done id4 ignored.
- Bypass: id3 done with data 0x55 and id5 not done; byp_id = {3,5,7,3} → byp_hit = 1,0,0,1 with data 0x55,0,0,0x55.
- Async reset asserted mid-stream with 5 entries live → outputs are 0 immediately, rob_empty = 1, and no rf_we after release.
